// File: rtl/instr_loader_if.sv
// Host byte stream plus instruction-memory write port of the instruction loader.
// The slave modport is the loader's view; the master modport is the host/memory side.
interface instr_loader_if #(
  parameter int IMEM_AW = 10
) ();
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_last;
  logic               in_ready;
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_addr;
  logic [8:0]         imem_wdata;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_loader.sv
// Packs a host byte stream LSB-first into 9-bit instructions and writes them to imem,
// holding the core idle (start=1) while loading and releasing it until done.
module instr_loader #(
  parameter int IMEM_AW = 10
) (
  input  logic             clk,
  input  logic             reset,
  instr_loader_if.slave    bus,
  output logic             start,
  input  logic             done,
  output logic             busy,
  output logic [IMEM_AW:0] loaded_count,
  output logic             err_overflow
);
  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_DRAIN = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  localparam logic [IMEM_AW:0]   CAP     = {1'b1, {IMEM_AW{1'b0}}};
  localparam logic [IMEM_AW-1:0] PTR_ONE = 1;
  localparam logic [IMEM_AW:0]   CNT_ONE = 1;

  state_e             state_q;
  logic [15:0]        acc_q;
  logic [3:0]         nbits_q;
  logic [IMEM_AW-1:0] wr_ptr_q;
  logic [IMEM_AW:0]   wr_cnt_q;
  logic [IMEM_AW:0]   loaded_count_q;
  logic               err_q;
  logic               we_q;
  logic [IMEM_AW-1:0] addr_q;
  logic [8:0]         wdata_q;
  logic               start_q;
  logic               busy_q;

  logic [15:0] merged_s;
  logic [4:0]  nsum_s;
  logic        accept_s;
  logic        emit_s;
  logic [8:0]  word_s;
  logic [15:0] acc_d;
  logic [3:0]  nbits_d;

  assign bus.in_ready   = (state_q == S_LOAD) && !reset;
  assign accept_s       = bus.in_valid && bus.in_ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign start          = start_q;
  assign busy           = busy_q;
  assign loaded_count   = loaded_count_q;
  assign err_overflow   = err_q;

  // Merge the incoming byte above the pending bits and peel off one word if complete.
  always_comb begin
    merged_s = acc_q | ({8'd0, bus.in_data} << nbits_q);
    nsum_s   = {1'b0, nbits_q} + 5'd8;
    emit_s   = (nsum_s >= 5'd9);
    word_s   = merged_s[8:0];
    if (emit_s) begin
      acc_d   = merged_s >> 4'd9;
      nbits_d = nsum_s[3:0] - 4'd9;
    end else begin
      acc_d   = merged_s;
      nbits_d = nsum_s[3:0];
    end
  end

  // wr_cnt_q counts words issued so far, one cycle ahead of loaded_count_q, so that
  // overflow and the empty-program test see a word still in flight on the write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_LOAD;
      acc_q          <= 16'd0;
      nbits_q        <= 4'd0;
      wr_ptr_q       <= '0;
      wr_cnt_q       <= '0;
      loaded_count_q <= '0;
      err_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= 9'd0;
      start_q        <= 1'b1;
      busy_q         <= 1'b0;
    end else begin
      we_q           <= 1'b0;
      loaded_count_q <= loaded_count_q + {{IMEM_AW{1'b0}}, we_q};
      case (state_q)
        S_LOAD: begin
          if (accept_s) begin
            acc_q   <= acc_d;
            nbits_q <= nbits_d;
            if (emit_s) begin
              if (wr_cnt_q == CAP) begin
                err_q <= 1'b1;
              end else begin
                we_q     <= 1'b1;
                addr_q   <= wr_ptr_q;
                wdata_q  <= word_s;
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
                wr_cnt_q <= wr_cnt_q + CNT_ONE;
              end
            end
            if (bus.in_last) begin
              acc_q   <= 16'd0;
              nbits_q <= 4'd0;
              state_q <= S_DRAIN;
              busy_q  <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (wr_cnt_q == '0) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b0;
          end else begin
            state_q <= S_RUN;
            start_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (done) begin
            state_q        <= S_LOAD;
            start_q        <= 1'b1;
            busy_q         <= 1'b0;
            wr_ptr_q       <= '0;
            wr_cnt_q       <= '0;
            loaded_count_q <= '0;
          end
        end
        default: begin
          state_q <= S_LOAD;
          start_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule
